// File: rtl/pipeline_hazard_controller.sv
// Pipeline stall/flush sequencer: load-use, mult/div occupancy and taken-branch flush
// combined into one set of Mealy control strobes, plus debug state and stall counter.
module pipeline_hazard_controller #(
  parameter int MULDIV_LAT = 32,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             MemRead_EX,
  input  logic [4:0]       Rt_EX,
  input  logic [4:0]       Rs_ID,
  input  logic [4:0]       Rt_ID,
  input  logic             UseRs_ID,
  input  logic             UseRt_ID,
  input  logic             MulDivStart_ID,
  input  logic             MfHiLo_ID,
  input  logic             BranchTaken_EX,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXBubble,
  output logic             MulDivBusy,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] StallCount
);

  localparam int MD_W = $clog2(MULDIV_LAT + 1);
  localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MULDIV_LAT);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_MDWAIT  = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [MD_W-1:0]  mdcnt_reg, mdcnt_next;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic             flush_cond, ld_cond, md_cond, issue, stalling;

  assign MulDivBusy = (mdcnt_reg != '0);

  always_comb begin
    flush_cond = BranchTaken_EX;
    ld_cond    = MemRead_EX && (Rt_EX != 5'd0) &&
                 ((UseRs_ID && (Rs_ID == Rt_EX)) || (UseRt_ID && (Rt_ID == Rt_EX)));
    md_cond    = MulDivBusy && (MulDivStart_ID || MfHiLo_ID);
  end

  // Decision and strobes; Reset forces a held, squashed pipeline front end.
  always_comb begin
    state_next = ST_RUN;
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXBubble = 1'b0;
    if (flush_cond) begin
      state_next = ST_FLUSH;
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
    end else if (ld_cond || md_cond) begin
      state_next = ld_cond ? ST_LDSTALL : ST_MDWAIT;
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
    end
    if (Reset) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
    end
  end

  always_comb begin
    issue    = (state_next == ST_RUN) && MulDivStart_ID;
    stalling = (state_next == ST_LDSTALL) || (state_next == ST_MDWAIT);

    mdcnt_next = mdcnt_reg;
    if (issue)
      mdcnt_next = MD_LOAD;
    else if (mdcnt_reg != '0)
      mdcnt_next = mdcnt_reg - MD_W'(1);

    stall_cnt_next = stall_cnt_reg;
    if (stalling && (stall_cnt_reg != '1))
      stall_cnt_next = stall_cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg     <= ST_RUN;
      mdcnt_reg     <= '0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      mdcnt_reg     <= mdcnt_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign State      = state_reg;
  assign StallCount = stall_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (MULDIV_LAT=4, CNT_W=4).
module tb_pipeline_hazard_controller;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       MemRead_EX;
  logic [4:0] Rt_EX, Rs_ID, Rt_ID;
  logic       UseRs_ID, UseRt_ID, MulDivStart_ID, MfHiLo_ID, BranchTaken_EX;
  logic       PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulDivBusy;
  logic [1:0] State;
  logic [3:0] StallCount;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_controller #(.MULDIV_LAT(4), .CNT_W(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .MemRead_EX(MemRead_EX), .Rt_EX(Rt_EX), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
    .UseRs_ID(UseRs_ID), .UseRt_ID(UseRt_ID),
    .MulDivStart_ID(MulDivStart_ID), .MfHiLo_ID(MfHiLo_ID),
    .BranchTaken_EX(BranchTaken_EX),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
    .IDEXBubble(IDEXBubble), .MulDivBusy(MulDivBusy),
    .State(State), .StallCount(StallCount)
  );

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %0h (t=%0t)", tag, got, $time);
    end
  endtask

  task automatic idle();
    MemRead_EX = 0; Rt_EX = 0; Rs_ID = 0; Rt_ID = 0;
    UseRs_ID = 0; UseRt_ID = 0; MulDivStart_ID = 0; MfHiLo_ID = 0; BranchTaken_EX = 0;
  endtask

  task automatic set_ld(input logic [4:0] rt_ex, input logic [4:0] rs, input logic use_rs,
                        input logic [4:0] rt, input logic use_rt);
    MemRead_EX = 1; Rt_EX = rt_ex; Rs_ID = rs; UseRs_ID = use_rs; Rt_ID = rt; UseRt_ID = use_rt;
  endtask

  // Inputs change on the falling edge; comb outputs are sampled 1ns later.
  task automatic nxt();
    @(negedge Clk);
  endtask

  task automatic pulse_reset();
    nxt();
    idle();
    Reset = 1; #2; Reset = 0;
    nxt();
  endtask

  task automatic chk_strobes(input string tag, input logic pc, input logic ifw,
                             input logic fl, input logic bub);
    check_val({tag, ".PCWrite"}, 32'(PCWrite), 32'(pc));
    check_val({tag, ".IFIDWrite"}, 32'(IFIDWrite), 32'(ifw));
    check_val({tag, ".IFIDFlush"}, 32'(IFIDFlush), 32'(fl));
    check_val({tag, ".IDEXBubble"}, 32'(IDEXBubble), 32'(bub));
  endtask

  initial begin
    int exp_cnt;
    idle();
    Reset = 1;

    // Reset behaviour, including asynchronous abort of a busy mult/div
    nxt(); #1;
    chk_strobes("rst_hold", 0, 0, 1, 1);
    Reset = 0;
    set_ld(5'd7, 5'd7, 1, 5'd0, 0);
    #1 check_val("pre_ld.PCWrite", 32'(PCWrite), 0);
    nxt(); idle(); MulDivStart_ID = 1;
    #1 check_val("pre_cnt", 32'(StallCount), 1);
    nxt(); idle();
    #1 check_val("pre_busy", 32'(MulDivBusy), 1);
    #1 Reset = 1;
    #1 check_val("async_busy", 32'(MulDivBusy), 0);
    check_val("async_cnt", 32'(StallCount), 0);
    check_val("async_state", 32'(State), 0);
    chk_strobes("async_rst", 0, 0, 1, 1);
    Reset = 0;
    nxt(); #1;
    chk_strobes("post_rst", 1, 1, 0, 0);
    check_val("post_rst.State", 32'(State), 0);
    check_val("post_rst.Cnt", 32'(StallCount), 0);
    check_val("post_rst.Busy", 32'(MulDivBusy), 0);

    // Load-use hazard on rs, then non-stalling variants, then rt
    nxt(); set_ld(5'd5, 5'd5, 1, 5'd0, 0);
    #1 chk_strobes("ld_rs", 0, 0, 0, 1);
    nxt(); set_ld(5'd0, 5'd0, 1, 5'd0, 1);
    #1 check_val("ld_rs.State", 32'(State), 1);
    check_val("ld_rs.Cnt", 32'(StallCount), 1);
    chk_strobes("ld_rt0", 1, 1, 0, 0);
    nxt(); set_ld(5'd5, 5'd5, 0, 5'd9, 1);
    #1 check_val("ld_rt0.State", 32'(State), 0);
    check_val("ld_rt0.Cnt", 32'(StallCount), 1);
    chk_strobes("ld_nouse", 1, 1, 0, 0);
    nxt(); set_ld(5'd9, 5'd1, 1, 5'd9, 1);
    #1 check_val("ld_nouse.State", 32'(State), 0);
    chk_strobes("ld_rt", 0, 0, 0, 1);
    nxt(); idle();
    #1 check_val("ld_rt.State", 32'(State), 1);
    check_val("ld_rt.Cnt", 32'(StallCount), 2);

    // mult then immediate mfhi: four MDWAIT cycles
    pulse_reset();
    MulDivStart_ID = 1;
    #1 check_val("mul_issue.PCWrite", 32'(PCWrite), 1);
    check_val("mul_issue.Busy", 32'(MulDivBusy), 0);
    for (int i = 0; i < 4; i++) begin
      nxt(); idle(); MfHiLo_ID = 1;
      #1 check_val($sformatf("mf_wait%0d.Busy", i), 32'(MulDivBusy), 1);
      chk_strobes($sformatf("mf_wait%0d", i), 0, 0, 0, 1);
      check_val($sformatf("mf_wait%0d.Cnt", i), 32'(StallCount), 32'(i));
    end
    nxt();
    #1 check_val("mf_go.Busy", 32'(MulDivBusy), 0);
    check_val("mf_go.State", 32'(State), 2);
    check_val("mf_go.Cnt", 32'(StallCount), 4);
    chk_strobes("mf_go", 1, 1, 0, 0);
    nxt(); idle();
    #1 check_val("mf_done.State", 32'(State), 0);

    // Back-to-back div: second waits for count 0 then reloads
    pulse_reset();
    MulDivStart_ID = 1;
    for (int i = 0; i < 4; i++) begin
      nxt();
      #1 check_val($sformatf("div2_wait%0d.PCWrite", i), 32'(PCWrite), 0);
      check_val($sformatf("div2_wait%0d.State", i), 32'(State), (i == 0) ? 0 : 2);
    end
    nxt();
    #1 check_val("div2_issue.Busy", 32'(MulDivBusy), 0);
    check_val("div2_issue.PCWrite", 32'(PCWrite), 1);
    nxt(); idle();
    #1 check_val("div2_reload.Busy", 32'(MulDivBusy), 1);
    check_val("div2_reload.Cnt", 32'(StallCount), 4);
    check_val("div2_reload.State", 32'(State), 0);
    nxt(); nxt(); nxt();
    #1 check_val("div2_last.Busy", 32'(MulDivBusy), 1);
    nxt();
    #1 check_val("div2_end.Busy", 32'(MulDivBusy), 0);

    // Flush beats load-use and mult issue
    pulse_reset();
    set_ld(5'd3, 5'd3, 1, 5'd0, 0); MulDivStart_ID = 1; BranchTaken_EX = 1;
    #1 chk_strobes("flush", 1, 1, 1, 1);
    nxt(); idle();
    #1 check_val("flush.State", 32'(State), 3);
    check_val("flush.Cnt", 32'(StallCount), 0);
    check_val("flush.Busy", 32'(MulDivBusy), 0);

    // ld and md together: one count, State LDSTALL
    pulse_reset();
    MulDivStart_ID = 1;
    nxt(); idle(); set_ld(5'd4, 5'd4, 1, 5'd0, 0); MfHiLo_ID = 1;
    #1 chk_strobes("ldmd", 0, 0, 0, 1);
    nxt(); idle();
    #1 check_val("ldmd.State", 32'(State), 1);
    check_val("ldmd.Cnt", 32'(StallCount), 1);

    // 20 load-use stalls saturate a 4-bit counter at 15
    pulse_reset();
    set_ld(5'd2, 5'd2, 1, 5'd0, 0);
    for (int i = 1; i <= 20; i++) begin
      nxt();
      exp_cnt = (i > 15) ? 15 : i;
      #1 check_val($sformatf("sat%0d.Cnt", i), 32'(StallCount), 32'(exp_cnt));
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
